recomplementer: RTL and testbench

Bit-serial result-correction stage for the ALU subtract path. The complement-and-add path produces a raw WIDTH-bit sum plus end carry. This block takes that sum and turns it back into sign-magnitude form, either by recomplementing it or by applying the end-around carry. It sits between the adder and the result register and uses a valid/ready handshake on both sides.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/recomplementer_if.sv | 25 ++
 rtl/recomp_bit_cell.sv | 31 +++
 rtl/recomplementer.sv | 101 ++++++++++
 tb/tb_recomplementer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the subtract-path result-correction stage: FSM states,
// subtract-mode constants and the per-bit operation encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic MODE_ONES = 1'b0;
  localparam logic MODE_TWOS = 1'b1;

  typedef enum logic [1:0] {
    OP_INC  = 2'd0,  // one's-complement positive: end-around +1
    OP_INV  = 2'd1,  // one's-complement negative: invert
    OP_PASS = 2'd2,  // two's-complement positive: copy
    OP_NEG  = 2'd3   // two's-complement negative: copy through first 1, then invert
  } op_e;

  function automatic op_e op_select(logic mode, logic cout);
    op_e op;
    if (mode == MODE_ONES) op = cout ? OP_INC : OP_INV;
    else                   op = cout ? OP_PASS : OP_NEG;
    return op;
  endfunction

endpackage

// File: rtl/recomplementer_if.sv
// Valid/ready bundle between the adder, the correction stage and the result register.
interface recomplementer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_mag;
  logic             out_neg;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, in_cout, in_mode, out_ready,
    input  in_ready, out_valid, out_mag, out_neg, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_cout, in_mode, out_ready,
    output in_ready, out_valid, out_mag, out_neg, out_ovf
  );
endinterface

// File: rtl/recomp_bit_cell.sv
// One bit of serial correction; the flag is the increment carry or the
// "a 1 has already been copied" marker depending on the operation.
module recomp_bit_cell
  import alu_pkg::*;
(
  input  logic bit_i,
  input  op_e  op_i,
  input  logic flag_i,
  output logic res_o,
  output logic flag_o
);

  always_comb begin
    res_o  = bit_i;
    flag_o = flag_i;
    unique case (op_i)
      OP_INC: begin
        res_o  = bit_i ^ flag_i;
        flag_o = bit_i & flag_i;
      end
      OP_INV:  res_o = ~bit_i;
      OP_PASS: res_o = bit_i;
      OP_NEG: begin
        res_o  = flag_i ? ~bit_i : bit_i;
        flag_o = flag_i | bit_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/recomplementer.sv
// Bit-serial conversion of the raw complement-and-add sum back into
// sign-magnitude form, LSB first, with valid/ready on both sides.
module recomplementer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  recomplementer_if.slave        bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-2:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             flag_q;
  logic             cout_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_mag_q;
  logic             out_neg_q;
  logic             out_ovf_q;

  logic             res_bit;
  logic             flag_d;
  logic [WIDTH-1:0] mag_d;
  op_e              op_d;

  recomp_bit_cell u_cell (
    .bit_i  (sum_q[0]),
    .op_i   (op_q),
    .flag_i (flag_q),
    .res_o  (res_bit),
    .flag_o (flag_d)
  );

  // Result bits enter at the MSB; after the last shift this is the full magnitude.
  assign mag_d = {res_bit, acc_q};
  assign op_d  = op_select(bus.in_mode, bus.in_cout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_INC;
      sum_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_neg_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sum_q   <= bus.in_sum;
            cout_q  <= bus.in_cout;
            op_q    <= op_d;
            // Increment path starts with carry-in 1; negate path starts with no 1 seen.
            flag_q  <= (op_d == OP_INC);
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sum_q  <= sum_q >> 1;
          acc_q  <= mag_d[WIDTH-1:1];
          flag_q <= flag_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            out_valid_q <= 1'b1;
            out_mag_q   <= mag_d;
            // Negative zero from the invert path folds to +0.
            out_neg_q   <= ~cout_q & (|mag_d);
            out_ovf_q   <= (op_q == OP_INC) & flag_d;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_mag   = out_mag_q;
  assign bus.out_neg   = out_neg_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_recomplementer.sv
// Scoreboard bench for recomplementer at WIDTH=4: expectations come from an
// arithmetic model of sign-magnitude correction.
module tb_recomplementer;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] mag;
    logic         neg;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  recomplementer_if #(.WIDTH(W)) bus ();

  recomplementer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [W-1:0] s, logic c, logic m);
    exp_t e;
    logic [W:0] w;
    e.ovf = 1'b0;
    e.neg = 1'b0;
    if (m == 1'b0 && c) begin
      w     = {1'b0, s} + (W+1)'(1);
      e.mag = w[W-1:0];
      e.ovf = w[W];
    end else if (m == 1'b0) begin
      e.mag = ~s;
      e.neg = (e.mag != '0);
    end else if (c) begin
      e.mag = s;
    end else begin
      e.mag = W'(0) - s;
      e.neg = (e.mag != '0);
    end
    return e;
  endfunction

  // Present a word, wait for in_ready, accept on the next edge, push expectation.
  task automatic drive_word(input logic [W-1:0] s, input logic c, input logic m);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_cout  = c;
    bus.in_mode  = m;
    while (!bus.in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(model(s, c, m));
  endtask

  // Wait (bounded) for out_valid, capture the result, then handshake it away.
  task automatic collect(output exp_t got, output int lat, output bit ok);
    int n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    ok  = bus.out_valid;
    lat = n;
    got = '{mag: bus.out_mag, neg: bus.out_neg, ovf: bus.out_ovf};
    if (ok) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_mag !== 4'b0000 ||
        bus.out_neg !== 1'b0 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b mag=%b neg=%b ovf=%b required 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.out_mag, bus.out_neg, bus.out_ovf);
    end
  endtask

  task automatic test_ones();
    logic [W-1:0] sums[3] = '{4'b1010, 4'b0010, 4'b1111};
    logic         couts[3] = '{1'b0, 1'b1, 1'b1};
    exp_t got, e;
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      drive_word(sums[i], couts[i], 1'b0);
      collect(got, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL ones_%0d: ok=%0d got mag=%b neg=%b ovf=%b required mag=%b neg=%b ovf=%b",
                 i, ok, got.mag, got.neg, got.ovf, e.mag, e.neg, e.ovf);
      end
      if (i == 0) begin
        checks++;
        if (lat != 4) begin
          errors++;
          $display("FAIL latency: got %0d cycles required 4", lat);
        end
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_mag !== e.mag ||
          bus.out_ovf !== e.ovf) begin
        errors++;
        $display("FAIL idle_hold_%0d: vld=%b rdy=%b mag=%b ovf=%b required 0 1 %b %b",
                 i, bus.out_valid, bus.in_ready, bus.out_mag, bus.out_ovf, e.mag, e.ovf);
      end
    end
  endtask

  task automatic test_twos();
    logic [W-1:0] sums[3] = '{4'b1101, 4'b0110, 4'b1000};
    logic         couts[3] = '{1'b0, 1'b1, 1'b0};
    exp_t got, e;
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      drive_word(sums[i], couts[i], 1'b1);
      collect(got, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL twos_%0d: ok=%0d got mag=%b neg=%b ovf=%b required mag=%b neg=%b ovf=%b",
                 i, ok, got.mag, got.neg, got.ovf, e.mag, e.neg, e.ovf);
      end
    end
  endtask

  task automatic test_neg_zero();
    exp_t got, e;
    int lat;
    bit ok;
    drive_word(4'b1111, 1'b0, 1'b0);
    collect(got, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e || got.neg !== 1'b0) begin
      errors++;
      $display("FAIL neg_zero: ok=%0d got mag=%b neg=%b ovf=%b required mag=0000 neg=0 ovf=0",
               ok, got.mag, got.neg, got.ovf);
    end
  endtask

  task automatic test_backpressure();
    exp_t got, e, first;
    int lat, n;
    bit ok;
    drive_word(4'b0011, 1'b0, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    first = '{mag: bus.out_mag, neg: bus.out_neg, ovf: bus.out_ovf};
    e = sb.pop_front();
    checks++;
    if (!bus.out_valid || first !== e) begin
      errors++;
      $display("FAIL bp_first: vld=%b got mag=%b neg=%b required mag=%b neg=%b",
               bus.out_valid, first.mag, first.neg, e.mag, e.neg);
    end
    bus.in_valid = 1'b1;
    bus.in_sum   = 4'b0100;
    bus.in_cout  = 1'b1;
    bus.in_mode  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_mag !== first.mag ||
          bus.out_neg !== first.neg || bus.out_ovf !== first.ovf) begin
        errors++;
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b mag=%b neg=%b required 1 0 %b %b",
                 i, bus.out_valid, bus.in_ready, bus.out_mag, bus.out_neg, first.mag, first.neg);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(model(4'b0100, 1'b1, 1'b0));
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: in_ready=%b required 0", bus.in_ready);
    end
    collect(got, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e || lat != 4) begin
      errors++;
      $display("FAIL bp_second: ok=%0d lat=%0d got mag=%b neg=%b ovf=%b required lat=4 mag=%b neg=%b ovf=%b",
               ok, lat, got.mag, got.neg, got.ovf, e.mag, e.neg, e.ovf);
    end
  endtask

  task automatic test_reset_abort();
    exp_t got, e;
    int lat, seen;
    bit ok;
    drive_word(4'b1010, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_mag !== 4'b0000 ||
        bus.out_neg !== 1'b0 || bus.out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: rdy=%b vld=%b mag=%b neg=%b ovf=%b required 1 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.out_mag, bus.out_neg, bus.out_ovf);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_valid: out_valid seen %0d cycles required 0", seen);
    end
    drive_word(4'b0111, 1'b1, 1'b0);
    collect(got, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL abort_next: ok=%0d got mag=%b neg=%b ovf=%b required mag=%b neg=%b ovf=%b",
               ok, got.mag, got.neg, got.ovf, e.mag, e.neg, e.ovf);
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, e;
    int lat;
    bit ok;
    logic [W-1:0] s;
    logic c, m;
    for (int i = 0; i < 16; i++) begin
      s = W'($urandom_range(0, 15));
      c = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      drive_word(s, c, m);
      collect(got, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e || lat != 4) begin
        errors++;
        $display("FAIL b2b_%0d: in=%b/%b/%b ok=%0d lat=%0d got %b/%b/%b required %b/%b/%b",
                 i, s, c, m, ok, lat, got.mag, got.neg, got.ovf, e.mag, e.neg, e.ovf);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_cout   = 1'b0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    test_reset();
    #21;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_ones();
    test_twos();
    test_neg_zero();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
